// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: control-word fields,
// next-PC select encodings, FSM state encodings and reset defaults.
package instruction_fetch_unit_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0;
  localparam logic [XLEN-1:0] PC_STEP          = 64'd4;

  typedef enum logic [1:0] {
    PC_SEL_INC    = 2'b00,
    PC_SEL_BRANCH = 2'b01,
    PC_SEL_REG    = 2'b10,
    PC_SEL_HOLD   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RESET_WAIT = 2'b00,
    ST_FETCH      = 2'b01,
    ST_EXEC       = 2'b10,
    ST_FAULT      = 2'b11
  } ifu_state_e;

  // PC-related slice of the control word produced by the control unit.
  typedef struct packed {
    pc_sel_e pc_sel;
    logic    pc_enable;
  } ctrl_word_pc_t;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection plus word-alignment check of the target.
module next_pc_calc
  import instruction_fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  pc_sel_e         pc_sel,
  input  logic [XLEN-1:0] literal,
  input  logic [XLEN-1:0] reg_target,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);

  logic [XLEN-1:0] branch_offset;

  // The shift drops literal[63:62]; all adds wrap modulo 2^64.
  assign branch_offset = literal << 2;
  assign pc_plus4      = pc + PC_STEP;

  always_comb begin
    next_pc = pc;
    case (pc_sel)
      PC_SEL_INC:    next_pc = pc_plus4;
      PC_SEL_BRANCH: next_pc = pc + branch_offset;
      PC_SEL_REG:    next_pc = reg_target;
      PC_SEL_HOLD:   next_pc = pc;
      default:       next_pc = pc;
    endcase
  end

  assign misaligned = !is_word_aligned(next_pc);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one instruction per retirement
// and traps permanently on a misaligned branch target.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      pc_sel,
  input  logic            pc_enable,
  input  logic            stall,
  input  logic [XLEN-1:0] literal,
  input  logic [XLEN-1:0] reg_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] instruction,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_fault
);

  // state         | meaning
  // ST_RESET_WAIT | one idle cycle after reset release
  // ST_FETCH      | imem_req high, waiting for imem_ack
  // ST_EXEC       | instruction held, waiting for a retiring control word
  // ST_FAULT      | misaligned target seen; only reset leaves

  ifu_state_e      state;
  ctrl_word_pc_t   ctrl;
  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;
  logic            retire;

  assign ctrl = '{pc_sel: pc_sel_e'(pc_sel), pc_enable: pc_enable};

  // pc_sel=HOLD behaves like a stall so multi-cycle instructions can park here.
  assign retire = ctrl.pc_enable && !stall && (ctrl.pc_sel != PC_SEL_HOLD);

  next_pc_calc u_next_pc_calc (
    .pc         (pc),
    .pc_sel     (ctrl.pc_sel),
    .literal    (literal),
    .reg_target (reg_target),
    .next_pc    (next_pc),
    .pc_plus4   (pc_plus4),
    .misaligned (next_misaligned)
  );

  assign imem_addr = pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_RESET_WAIT;
      pc          <= RESET_PC;
      instruction <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      pc_fault    <= 1'b0;
    end else begin
      case (state)
        ST_RESET_WAIT: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
        end
        ST_FETCH: begin
          imem_req <= 1'b1;
          if (imem_ack) begin
            instruction <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (retire) begin
            instr_valid <= 1'b0;
            if (next_misaligned) begin
              pc_fault <= 1'b1;
              state    <= ST_FAULT;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end
          end
        end
        ST_FAULT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          pc_fault    <= 1'b1;
        end
        default: begin
          state    <= ST_FAULT;
          imem_req <= 1'b0;
          pc_fault <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic against a cycle-level behavioural model.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pc_sel = 2'b00;
  logic        pc_enable = 1'b0;
  logic        stall = 1'b0;
  logic [63:0] literal = '0;
  logic [63:0] reg_target = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic        pc_fault;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  instruction_fetch_unit dut (
    .clock(clock), .reset(reset), .pc_sel(pc_sel), .pc_enable(pc_enable),
    .stall(stall), .literal(literal), .reg_target(reg_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instruction(instruction),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .pc_fault(pc_fault)
  );

  always #5 clock = ~clock;

  // Behavioural model: boot pending -> waiting for memory -> holding an
  // instruction -> (retire) back to waiting; a misaligned target traps.
  logic [63:0] m_pc = 64'h0;
  logic [31:0] m_instr = '0;
  bit          m_boot = 1, m_req = 0, m_valid = 0, m_fault = 0;

  always @(posedge clock or posedge reset) begin
    logic [63:0] t;
    if (reset) begin
      m_pc = 64'h0; m_instr = '0; m_valid = 0; m_req = 0; m_fault = 0; m_boot = 1;
    end else if (!m_fault) begin
      if (m_boot) begin
        m_boot = 0; m_req = 1;
      end else if (m_req) begin
        if (imem_ack) begin m_instr = imem_rdata; m_valid = 1; m_req = 0; end
      end else if (m_valid && pc_enable && !stall && pc_sel != 2'b11) begin
        case (pc_sel)
          2'b00:   t = m_pc + 64'd4;
          2'b01:   t = m_pc + literal * 64'd4;
          default: t = reg_target;
        endcase
        m_valid = 0;
        if (t % 64'd4 != 0) m_fault = 1;
        else begin m_pc = t; m_req = 1; end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (check_en) begin
      check("imem_req", {63'd0, imem_req}, {63'd0, m_req});
      check("imem_addr", imem_addr, m_pc);
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 64'd4);
      check("instruction", {32'd0, instruction}, {32'd0, m_instr});
      check("instr_valid", {63'd0, instr_valid}, {63'd0, m_valid});
      check("pc_fault", {63'd0, pc_fault}, {63'd0, m_fault});
    end
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic fetch_now(input logic [31:0] data);
    imem_ack = 1'b1; imem_rdata = data;
    cyc();
    imem_ack = 1'b0;
  endtask

  task automatic retire(input logic [1:0] sel, input logic [63:0] lit, input logic [63:0] tgt);
    pc_sel = sel; literal = lit; reg_target = tgt; pc_enable = 1'b1;
    cyc();
    pc_enable = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    // Reset state
    reset = 1'b1;
    cyc();
    check_en = 1;
    check("rst_pc", pc, 64'h0);
    check("rst_instruction", {32'd0, instruction}, 64'h0);
    check("rst_valid", {63'd0, instr_valid}, 64'h0);
    check("rst_req", {63'd0, imem_req}, 64'h0);
    check("rst_fault", {63'd0, pc_fault}, 64'h0);
    cyc();
    reset = 1'b0;

    // First fetch, ack two cycles into the request
    cyc();
    check("boot_req", {63'd0, imem_req}, 64'h1);
    check("boot_addr", imem_addr, 64'h0);
    cyc();
    fetch_now(32'h8B020020);
    check("first_instr", {32'd0, instruction}, 64'h8B020020);
    check("first_valid", {63'd0, instr_valid}, 64'h1);
    check("first_pc", pc, 64'h0);
    check("first_req_drop", {63'd0, imem_req}, 64'h0);

    // Relative branch backwards by two words from 0x100
    retire(2'b10, 64'h0, 64'h100);
    check("jump_pc", pc, 64'h100);
    fetch_now(32'h1111_0001);
    retire(2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0);
    check("branch_pc", pc, 64'hF8);
    check("branch_fetch", {63'd0, imem_req}, 64'h1);
    check("branch_valid", {63'd0, instr_valid}, 64'h0);

    // PC+4 wraps at the top of the address space
    fetch_now(32'h2222_0002);
    retire(2'b10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    check("top_plus4", pc_plus4, 64'h0);
    fetch_now(32'h3333_0003);
    retire(2'b00, 64'h0, 64'h0);
    check("wrap_pc", pc, 64'h0);

    // Holding: pc_enable low, stall, and pc_sel=11
    fetch_now(32'h4444_0004);
    held = instruction;
    pc_sel = 2'b00;
    repeat (3) begin
      cyc();
      check("hold_en_pc", pc, 64'h0);
    end
    pc_enable = 1'b1; stall = 1'b1;
    repeat (2) begin
      cyc();
      check("hold_stall_pc", pc, 64'h0);
      check("hold_stall_instr", {32'd0, instruction}, {32'd0, held});
    end
    stall = 1'b0; pc_sel = 2'b11;
    cyc();
    check("hold_sel_pc", pc, 64'h0);
    pc_sel = 2'b00;
    cyc();
    pc_enable = 1'b0;
    check("release_pc", pc, 64'h4);

    // Misaligned register target traps until reset
    fetch_now(32'h5555_0005);
    retire(2'b10, 64'h0, 64'h202);
    check("fault_flag", {63'd0, pc_fault}, 64'h1);
    check("fault_pc", pc, 64'h4);
    imem_ack = 1'b1; pc_enable = 1'b1;
    repeat (4) begin
      cyc();
      check("fault_req", {63'd0, imem_req}, 64'h0);
      check("fault_valid", {63'd0, instr_valid}, 64'h0);
    end
    imem_ack = 1'b0; pc_enable = 1'b0;

    // Reset mid-fetch with a simultaneous ack
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    check("refetch_req", {63'd0, imem_req}, 64'h1);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; reset = 1'b1;
    #1;
    check("midreset_req", {63'd0, imem_req}, 64'h0);
    check("midreset_pc", pc, 64'h0);
    check("midreset_valid", {63'd0, instr_valid}, 64'h0);
    check("midreset_fault", {63'd0, pc_fault}, 64'h0);
    cyc();
    reset = 1'b0; imem_ack = 1'b0;
    cyc();
    check("ack_discarded", {32'd0, instruction}, 64'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      imem_ack   = ($urandom_range(0, 1) == 1);
      imem_rdata = $urandom;
      stall      = ($urandom_range(0, 3) == 0);
      pc_enable  = ($urandom_range(0, 4) < 3);
      pc_sel     = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) literal = {$urandom, $urandom};
      else literal = 64'($signed(32'($urandom_range(0, 64)) - 32));
      reg_target = {$urandom, $urandom & 32'hFFFF_FFFC};
      if ($urandom_range(0, 24) == 0) reg_target[1:0] = 2'($urandom_range(1, 3));
      reset = (m_fault && $urandom_range(0, 5) == 0) || ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
